dmem_ctrl: RTL and testbench

Data-memory access controller between the execute stage and a word-wide single-port synchronous data RAM. It accepts one load or store per request, using the memory-op encoding the decoder emits (write flag plus funct3 width/sign code). It performs byte/half/word accesses on a RAM with no byte enables, using read-modify-write for sub-word stores. Loads return sign- or zero-extended data, and each request gets a single-cycle response pulse.

---
 rtl/dmem_pkg.sv | 18 +
 rtl/dmem_lane.sv | 40 ++++
 rtl/dmem_ctrl.sv | 122 ++++++++++++
 tb/tb_dmem_ctrl.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory access controller.
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    StIdle,
    StRd,
    StCap,
    StWr,
    StResp
  } dmem_state_t;

endpackage

// File: rtl/dmem_lane.sv
// Lane logic: extracts and extends load data, merges sub-word store data into a RAM word.
module dmem_lane
  import dmem_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  addr_i,
  input  logic [31:0] word_i,
  input  logic [31:0] data_i,
  output logic [31:0] load_o,
  output logic [31:0] merge_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic        uns;

  always_comb begin
    byte_sel = word_i[{addr_i, 3'b000} +: 8];
    half_sel = addr_i[1] ? word_i[31:16] : word_i[15:0];
    uns      = funct3_i[2];
    load_o   = word_i;
    merge_o  = word_i;
    // Size comes from funct3[1:0] only, so illegal codes fall through as word accesses.
    case (funct3_i[1:0])
      F3_B[1:0]: begin
        load_o = {{24{~uns & byte_sel[7]}}, byte_sel};
        merge_o[{addr_i, 3'b000} +: 8] = data_i[7:0];
      end
      F3_H[1:0]: begin
        load_o = {{16{~uns & half_sel[15]}}, half_sel};
        merge_o[{addr_i[1], 4'b0000} +: 16] = data_i[15:0];
      end
      default: begin
        load_o  = word_i;
        merge_o = data_i;
      end
    endcase
  end

endmodule

// File: rtl/dmem_ctrl.sv
// Load/store controller for a word-wide RAM without byte enables (RMW for sub-word stores).
// Define DMEM_MISALIGN_TRAP_EN to trap misaligned and illegal accesses instead of masking them.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 17
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [31:0]           req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  resp_valid,
  output logic [31:0]           resp_rdata,
  output logic                  resp_err,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-3:0] mem_addr,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata
);

  dmem_state_t           state_q, state_d;
  logic                  we_q, we_d;
  logic [2:0]            f3_q, f3_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           data_q, data_d;
  logic                  err_q, err_d;
  logic                  req_err;
  logic [31:0]           lane_load, lane_merge;
  logic                  unused_addr;

  assign unused_addr = ^req_addr[31:ADDR_WIDTH];

`ifdef DMEM_MISALIGN_TRAP_EN
  always_comb begin
    case (req_funct3)
      F3_B, F3_BU: req_err = 1'b0;
      F3_H, F3_HU: req_err = req_addr[0];
      F3_W:        req_err = |req_addr[1:0];
      default:     req_err = 1'b1;
    endcase
  end
  assign resp_err = (state_q == StResp) & err_q;
`else
  assign req_err  = 1'b0;
  assign resp_err = 1'b0;
`endif

  dmem_lane u_lane (
    .funct3_i (f3_q),
    .addr_i   (addr_q[1:0]),
    .word_i   (mem_rdata),
    .data_i   (data_q),
    .load_o   (lane_load),
    .merge_o  (lane_merge)
  );

  // data_q holds store data until CAP, then the merged word (store) or extended result (load).
  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    f3_d    = f3_q;
    addr_d  = addr_q;
    data_d  = data_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          we_d   = req_we;
          f3_d   = req_funct3;
          addr_d = req_addr[ADDR_WIDTH-1:0];
          data_d = req_wdata;
          err_d  = req_err;
          if (req_err)                     state_d = StResp;
          else if (req_we && req_funct3[1]) state_d = StWr;
          else                             state_d = StRd;
        end
      end
      StRd:   state_d = StCap;
      StCap: begin
        data_d  = we_q ? lane_merge : lane_load;
        state_d = we_q ? StWr : StResp;
      end
      StWr:   state_d = StResp;
      StResp: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      we_q    <= 1'b0;
      f3_q    <= 3'b000;
      addr_q  <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      f3_q    <= f3_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    req_ready  = (state_q == StIdle);
    mem_en     = (state_q == StRd) || (state_q == StWr);
    mem_we     = (state_q == StWr);
    mem_addr   = mem_en ? addr_q[ADDR_WIDTH-1:2] : '0;
    mem_wdata  = mem_we ? data_q : '0;
    resp_valid = (state_q == StResp);
    resp_rdata = (resp_valid && !we_q && !err_q) ? data_q : '0;
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Self-checking bench for dmem_ctrl: directed cases plus random loads/stores against a byte-level model.
module tb_dmem_ctrl;
  import dmem_pkg::*;

  localparam int unsigned AW = 17;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid, req_ready, req_we;
  logic [2:0]    req_funct3;
  logic [31:0]   req_addr, req_wdata;
  logic          resp_valid, resp_err;
  logic [31:0]   resp_rdata;
  logic          mem_en, mem_we;
  logic [AW-3:0] mem_addr;
  logic [31:0]   mem_wdata, mem_rdata;

  logic [31:0] ram [0:(1<<(AW-2))-1];
  logic [31:0] ram_rd;
  logic [7:0]  ref_b [0:(1<<AW)-1];

  int          total = 0;
  int          bad = 0;
  logic [31:0] last_rd;
  logic        last_err;

  dmem_ctrl #(.ADDR_WIDTH(AW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        ram_rd <= ram[mem_addr];
    end
  end
  assign mem_rdata = ram_rd;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_word(input int w);
    return {ref_b[4*w+3], ref_b[4*w+2], ref_b[4*w+1], ref_b[4*w]};
  endfunction

  // Byte-addressed reference: applies the access to ref_b and predicts the response.
  task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, output int lat, output int n_en,
                       output logic err, output logic [31:0] rd, output int a);
    int     nb;
    bit     uns;
    longint v;
    uns = 0;
    err = 1'b0;
    case (f3)
      3'd0: nb = 1;
      3'd1: nb = 2;
      3'd4: begin nb = 1; uns = 1; end
      3'd5: begin nb = 2; uns = 1; end
      default: begin
        nb = 4;
`ifdef DMEM_MISALIGN_TRAP_EN
        if (f3 != 3'd2) err = 1'b1;
`endif
      end
    endcase
    a = int'(addr & 32'h1FFFF);
`ifdef DMEM_MISALIGN_TRAP_EN
    if (a % nb != 0) err = 1'b1;
`endif
    a = a - (a % nb);
    rd = 32'h0;
    if (err) begin
      lat  = 1;
      n_en = 0;
    end else if (we) begin
      for (int i = 0; i < nb; i++) ref_b[a+i] = wd[8*i +: 8];
      lat  = (nb == 4) ? 2 : 4;
      n_en = (nb == 4) ? 1 : 2;
    end else begin
      v = 0;
      for (int i = 0; i < nb; i++) v = v + (longint'(ref_b[a+i]) << (8*i));
      if (!uns && nb < 4 && ref_b[a+nb-1][7]) v = v - (longint'(1) << (8*nb));
      rd   = v[31:0];
      lat  = 3;
      n_en = 1;
    end
  endtask

  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd);
    int          exp_lat, exp_en, lat, n_en, n_we, a;
    logic        exp_err;
    logic [31:0] exp_rd;
    bit          done;
    model(we, f3, addr, wd, exp_lat, exp_en, exp_err, exp_rd, a);
    @(negedge clk);
    chk("ready_idle", {31'b0, req_ready}, 32'd1);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wd;
    @(posedge clk);
    #1;
    // Keep valid high with junk fields while busy; they must be ignored.
    req_we     = 1'($urandom);
    req_funct3 = 3'($urandom);
    req_addr   = $urandom;
    req_wdata  = $urandom;
    lat  = 0;
    n_en = 0;
    n_we = 0;
    done = 0;
    while (!done && lat < 10) begin
      @(negedge clk);
      lat++;
      chk("ready_busy", {31'b0, req_ready}, 32'd0);
      if (mem_en) begin
        n_en++;
        chk("mem_addr", {17'b0, mem_addr}, a >> 2);
      end
      if (mem_we) n_we++;
      if (resp_valid) begin
        done     = 1;
        last_rd  = resp_rdata;
        last_err = resp_err;
        chk("resp_rdata", resp_rdata, exp_rd);
        chk("resp_err", {31'b0, resp_err}, {31'b0, exp_err});
      end
    end
    req_valid = 1'b0;
    chk("resp_latency", lat, exp_lat);
    chk("mem_en_count", n_en, exp_en);
    chk("mem_we_count", n_we, (we && !exp_err) ? 1 : 0);
    @(negedge clk);
    chk("ready_after", {31'b0, req_ready}, 32'd1);
    chk("resp_pulse", {31'b0, resp_valid}, 32'd0);
    chk("ram_word", ram[a>>2], ref_word(a >> 2));
  endtask

  initial begin
    int          we_seen, lat, n_en, a, k, n_en_b2b, resp1_k, resp2_k;
    logic        err;
    logic [31:0] rd, d, exp_ld;

    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_funct3 = 3'b000;
    req_addr   = 32'h0;
    req_wdata  = 32'h0;
    for (int i = 0; i < (1 << AW); i++) ref_b[i] = 8'h00;

    // Reset values
    @(negedge clk);
    chk("rst_ready", {31'b0, req_ready}, 32'd1);
    chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("rst_mem_en", {31'b0, mem_en}, 32'd0);
    chk("rst_mem_we", {31'b0, mem_we}, 32'd0);
    chk("rst_mem_addr", {17'b0, mem_addr}, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_resp_err", {31'b0, resp_err}, 32'd0);
    rst_n = 1'b1;

    for (int w = 0; w < 16; w++) do_req(1'b1, F3_W, 32'h100 + 32'(4*w), $urandom);

    do_req(1'b1, F3_W, 32'h100, 32'hDEADBEEF);
    do_req(1'b0, F3_W, 32'h100, 32'h0);
    chk("lw_100", last_rd, 32'hDEADBEEF);

    do_req(1'b1, F3_W, 32'h100, 32'h80FF7F01);
    do_req(1'b0, F3_B, 32'h101, 32'h0);
    chk("lb_101", last_rd, 32'h0000007F);
    do_req(1'b0, F3_B, 32'h103, 32'h0);
    chk("lb_103", last_rd, 32'hFFFFFF80);
    do_req(1'b0, F3_BU, 32'h102, 32'h0);
    chk("lbu_102", last_rd, 32'h000000FF);
    do_req(1'b0, F3_H, 32'h102, 32'h0);
    chk("lh_102", last_rd, 32'hFFFF80FF);
    do_req(1'b0, F3_HU, 32'h102, 32'h0);
    chk("lhu_102", last_rd, 32'h000080FF);

    do_req(1'b1, F3_W, 32'h100, 32'h11223344);
    do_req(1'b1, F3_B, 32'h102, 32'h000000AA);
    chk("sb_102_ram", ram[32'h40], 32'h11AA3344);

    do_req(1'b0, F3_W, 32'h102, 32'h0);
`ifdef DMEM_MISALIGN_TRAP_EN
    chk("lw_102_err", {31'b0, last_err}, 32'd1);
`else
    chk("lw_102_rd", last_rd, 32'h11AA3344);
`endif

    // Reset during CAP of an SB: the write must never be issued.
    we_seen = 0;
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_funct3 = F3_B;
    req_addr   = 32'h105;
    req_wdata  = 32'h0000005A;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    if (mem_we) we_seen++;
    @(negedge clk);
    if (mem_we) we_seen++;
    rst_n = 1'b0;
    #1;
    chk("midrst_ready", {31'b0, req_ready}, 32'd1);
    chk("midrst_mem_en", {31'b0, mem_en}, 32'd0);
    chk("midrst_resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("midrst_mem_wdata", mem_wdata, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (mem_we) we_seen++;
    end
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (mem_we) we_seen++;
    end
    chk("midrst_no_write", we_seen, 0);
    chk("midrst_ram", ram[32'h41], ref_word(32'h41));

    // Back-to-back: req_valid held high across an SW then an LW.
    d = $urandom;
    model(1'b1, F3_W, 32'h120, d, lat, n_en, err, rd, a);
    model(1'b0, F3_W, 32'h120, 32'h0, lat, n_en, err, exp_ld, a);
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_funct3 = F3_W;
    req_addr   = 32'h120;
    req_wdata  = d;
    @(posedge clk);
    #1;
    req_we     = 1'b0;
    req_wdata  = 32'h0;
    n_en_b2b = 0;
    resp1_k  = 0;
    resp2_k  = 0;
    for (k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (mem_en) n_en_b2b++;
      if (resp_valid && resp1_k == 0) resp1_k = k;
      else if (resp_valid) begin
        resp2_k = k;
        chk("b2b_rdata", resp_rdata, exp_ld);
        req_valid = 1'b0;
      end
    end
    req_valid = 1'b0;
    chk("b2b_resp1_cycle", resp1_k, 2);
    chk("b2b_resp2_cycle", resp2_k, 6);
    chk("b2b_mem_en_count", n_en_b2b, 2);

    // Random traffic over 0x100..0x13F with junk upper address bits.
    for (int n = 0; n < 300; n++) begin
      do_req(1'($urandom), 3'($urandom_range(0, 7)),
             ($urandom & 32'hFFFE0000) | (32'h100 + 32'($urandom_range(0, 63))), $urandom);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
